// File: rtl/incr_sched_pkg.sv
// incr_sched_pkg: shared types and default widths for the shared-incrementer
// scheduler (FSM state, lane IDs, lane widths).
package incr_sched_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        ID_SMALL = 2'd0,
        ID_QUAD  = 2'd1,
        ID_WIDE  = 2'd2
    } lane_id_t;

    localparam int SMALL_W_DEF = 2;
    localparam int QUAD_W_DEF  = 40;
    localparam int WIDE_W_DEF  = 70;
    localparam int CNT_W_DEF   = 16;

endpackage

// File: rtl/incr_rr_arb.sv
// incr_rr_arb: combinational 3-way round-robin arbiter.
// Ports: req_i (bit0 small, bit1 quad, bit2 wide), last_ptr_i (previous
// winner), en_i (grant opportunity) -> gnt_o (one-hot), win_o (encoded).
module incr_rr_arb
    import incr_sched_pkg::*;
(
    input  logic [2:0] req_i,
    input  lane_id_t   last_ptr_i,
    input  logic       en_i,
    output logic [2:0] gnt_o,
    output lane_id_t   win_o
);

    lane_id_t o0, o1, o2;

    // Search starts at the lane after the previous winner.
    always_comb begin
        o0 = ID_SMALL;
        o1 = ID_QUAD;
        o2 = ID_WIDE;
        unique case (last_ptr_i)
            ID_SMALL: begin
                o0 = ID_QUAD;
                o1 = ID_WIDE;
                o2 = ID_SMALL;
            end
            ID_QUAD: begin
                o0 = ID_WIDE;
                o1 = ID_SMALL;
                o2 = ID_QUAD;
            end
            default: begin
                o0 = ID_SMALL;
                o1 = ID_QUAD;
                o2 = ID_WIDE;
            end
        endcase
    end

    always_comb begin
        gnt_o = '0;
        win_o = ID_SMALL;
        if (en_i) begin
            if (req_i[o0]) begin
                gnt_o[o0] = 1'b1;
                win_o     = o0;
            end else if (req_i[o1]) begin
                gnt_o[o1] = 1'b1;
                win_o     = o1;
            end else if (req_i[o2]) begin
                gnt_o[o2] = 1'b1;
                win_o     = o2;
            end
        end
    end

endmodule

// File: rtl/incr_sched.sv
// incr_sched: three lanes (small/quad/wide) share one WIDE_W-bit +1 unit
// through a round-robin arbiter; one registered, lane-tagged response stream.
// Ports: clk, reset_l (async active-low); <lane>_valid/_ready/_data requests;
// rsp_valid/rsp_ready/rsp_id/rsp_data response; busy (response held).
// Define INCR_SCHED_STATS_EN to add saturating grant_cnt_{small,quad,wide}.
module incr_sched
    import incr_sched_pkg::*;
#(
    parameter int SMALL_W = SMALL_W_DEF,
    parameter int QUAD_W  = QUAD_W_DEF,
    parameter int WIDE_W  = WIDE_W_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset_l,
    input  logic              small_valid,
    output logic              small_ready,
    input  logic [SMALL_W-1:0] small_data,
    input  logic              quad_valid,
    output logic              quad_ready,
    input  logic [QUAD_W-1:0] quad_data,
    input  logic              wide_valid,
    output logic              wide_ready,
    input  logic [WIDE_W-1:0] wide_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [1:0]        rsp_id,
    output logic [WIDE_W-1:0] rsp_data,
    output logic              busy
`ifdef INCR_SCHED_STATS_EN
    ,
    output logic [CNT_W-1:0]  grant_cnt_small,
    output logic [CNT_W-1:0]  grant_cnt_quad,
    output logic [CNT_W-1:0]  grant_cnt_wide
`endif
);

    if (SMALL_W > WIDE_W || QUAD_W > WIDE_W || CNT_W < 1) begin : g_bad_cfg
        $error("incr_sched: lane widths must not exceed WIDE_W");
    end

    localparam logic [WIDE_W-1:0] ONE = WIDE_W'(1);
    // Truncate the shared sum back to each lane's own width.
    localparam logic [WIDE_W-1:0] SMALL_MASK =
        {WIDE_W{1'b1}} >> (WIDE_W - SMALL_W);
    localparam logic [WIDE_W-1:0] QUAD_MASK =
        {WIDE_W{1'b1}} >> (WIDE_W - QUAD_W);

    state_t            state_q, state_d;
    lane_id_t          last_ptr_q, last_ptr_d;
    lane_id_t          rsp_id_q, rsp_id_d;
    lane_id_t          win;
    logic [WIDE_W-1:0] rsp_data_q, rsp_data_d;
    logic [WIDE_W-1:0] operand, mask, incr;
    logic [2:0]        req, gnt;
    logic              grant_en, xfer;

    assign req = {wide_valid, quad_valid, small_valid};

    // Readies are forced low while in reset via the enable.
    assign grant_en = reset_l && (state_q == S_IDLE || rsp_ready);

    incr_rr_arb u_arb (
        .req_i      (req),
        .last_ptr_i (last_ptr_q),
        .en_i       (grant_en),
        .gnt_o      (gnt),
        .win_o      (win)
    );

    assign {wide_ready, quad_ready, small_ready} = gnt;
    assign xfer = |gnt;

    always_comb begin
        operand = '0;
        mask    = '0;
        unique case (1'b1)
            gnt[0]: begin
                operand = WIDE_W'(small_data);
                mask    = SMALL_MASK;
            end
            gnt[1]: begin
                operand = WIDE_W'(quad_data);
                mask    = QUAD_MASK;
            end
            gnt[2]: begin
                operand = wide_data;
                mask    = '1;
            end
            default: begin
                operand = '0;
                mask    = '0;
            end
        endcase
    end

    assign incr = (operand + ONE) & mask;

    always_comb begin
        state_d    = state_q;
        rsp_data_d = rsp_data_q;
        rsp_id_d   = rsp_id_q;
        last_ptr_d = last_ptr_q;
        if (xfer) begin
            rsp_data_d = incr;
            rsp_id_d   = win;
            last_ptr_d = win;
        end
        unique case (state_q)
            S_IDLE: begin
                if (xfer) state_d = S_HOLD;
            end
            S_HOLD: begin
                if (rsp_ready && !xfer) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state_q    <= S_IDLE;
            last_ptr_q <= ID_WIDE;
            rsp_id_q   <= ID_SMALL;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            last_ptr_q <= last_ptr_d;
            rsp_id_q   <= rsp_id_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    assign rsp_valid = (state_q == S_HOLD);
    assign busy      = (state_q == S_HOLD);
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;

`ifdef INCR_SCHED_STATS_EN
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q [3];
    logic [CNT_W-1:0] cnt_d [3];

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            cnt_d[i] = cnt_q[i];
            if (gnt[i] && cnt_q[i] != '1) cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign grant_cnt_small = cnt_q[0];
    assign grant_cnt_quad  = cnt_q[1];
    assign grant_cnt_wide  = cnt_q[2];
`endif

endmodule

// File: tb/tb_incr_sched.sv
// tb_incr_sched: directed stimulus with a response scoreboard for incr_sched.
// Build with INCR_SCHED_STATS_EN to also check the saturating grant counters.
module tb_incr_sched;
    import incr_sched_pkg::*;

    localparam int SW = 2;
    localparam int QW = 40;
    localparam int WW = 70;
`ifdef INCR_SCHED_STATS_EN
    localparam int CW = 4;
`else
    localparam int CW = 16;
`endif

    typedef struct packed {
        logic [1:0]    id;
        logic [WW-1:0] data;
    } rsp_t;

    logic          clk = 1'b0;
    logic          reset_l;
    logic          small_valid, small_ready;
    logic [SW-1:0] small_data;
    logic          quad_valid, quad_ready;
    logic [QW-1:0] quad_data;
    logic          wide_valid, wide_ready;
    logic [WW-1:0] wide_data;
    logic          rsp_valid, rsp_ready;
    logic [1:0]    rsp_id;
    logic [WW-1:0] rsp_data;
    logic          busy;
`ifdef INCR_SCHED_STATS_EN
    logic [CW-1:0] grant_cnt_small, grant_cnt_quad, grant_cnt_wide;
`endif

    rsp_t exp_q[$];
    rsp_t mon_e;
    int   vecs = 0;
    int   errs = 0;

    incr_sched #(
        .SMALL_W (SW),
        .QUAD_W  (QW),
        .WIDE_W  (WW),
        .CNT_W   (CW)
    ) dut (
        .clk         (clk),
        .reset_l     (reset_l),
        .small_valid (small_valid),
        .small_ready (small_ready),
        .small_data  (small_data),
        .quad_valid  (quad_valid),
        .quad_ready  (quad_ready),
        .quad_data   (quad_data),
        .wide_valid  (wide_valid),
        .wide_ready  (wide_ready),
        .wide_data   (wide_data),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_data    (rsp_data),
        .busy        (busy)
`ifdef INCR_SCHED_STATS_EN
        ,
        .grant_cnt_small (grant_cnt_small),
        .grant_cnt_quad  (grant_cnt_quad),
        .grant_cnt_wide  (grant_cnt_wide)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [WW-1:0] act,
                       input logic [WW-1:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [1:0] id, input logic [WW-1:0] d);
        rsp_t e;
        e.id   = id;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic summary();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    endtask

    // Monitor: inputs only change just after a rising edge, so the values
    // seen at the falling edge are the ones the next rising edge acts on.
    always @(negedge clk) begin
        if (reset_l === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                vecs++;
                errs++;
                $display("FAIL rsp_unexpected: got id %0d data %0h, required none",
                         rsp_id, rsp_data);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rsp_id", WW'(rsp_id), WW'(mon_e.id));
                chk("rsp_data", rsp_data, mon_e.data);
            end
        end
    end

    initial begin
        #200000;
        errs++;
        $display("FAIL watchdog: got timeout, required completion");
        summary();
        $fatal(1, "watchdog");
    end

    initial begin
        logic [QW-1:0] q_ones;
        logic [WW-1:0] w_ones;
        q_ones = '1;
        w_ones = '1;

        reset_l     = 1'b0;
        rsp_ready   = 1'b0;
        small_valid = 1'b1;
        small_data  = '0;
        quad_valid  = 1'b0;
        quad_data   = '0;
        wide_valid  = 1'b0;
        wide_data   = '0;
        #2;
        chk("reset_rsp_valid", WW'(rsp_valid), 0);
        chk("reset_busy", WW'(busy), 0);
        chk("reset_rsp_id", WW'(rsp_id), 0);
        chk("reset_rsp_data", rsp_data, 0);
        chk("reset_readies", WW'({small_ready, quad_ready, wide_ready}), 0);
`ifdef INCR_SCHED_STATS_EN
        chk("reset_cnt", WW'({grant_cnt_small, grant_cnt_quad, grant_cnt_wide}), 0);
`endif
        step();
        step();
        small_valid = 1'b0;
        reset_l     = 1'b1;
        step();

        // Round robin with all three lanes valid.
        rsp_ready   = 1'b1;
        small_data  = 2'd1;
        quad_data   = 40'd5;
        wide_data   = 70'd9;
        small_valid = 1'b1;
        quad_valid  = 1'b1;
        wide_valid  = 1'b1;
        repeat (2) begin
            push(2'd0, 70'd2);
            push(2'd1, 70'd6);
            push(2'd2, 70'd10);
        end
        #1;
        chk("rr_first_small_ready", WW'({small_ready, quad_ready, wide_ready}), 4);
        repeat (6) step();
        small_valid = 1'b0;
        quad_valid  = 1'b0;
        wide_valid  = 1'b0;

        // Per-lane wraparound and an ordinary value.
        small_valid = 1'b1;
        small_data  = 2'b11;
        push(2'd0, 70'd0);
        step();
        small_valid = 1'b0;
        quad_valid  = 1'b1;
        quad_data   = q_ones;
        push(2'd1, 70'd0);
        step();
        quad_valid  = 1'b0;
        wide_valid  = 1'b1;
        wide_data   = w_ones;
        push(2'd2, 70'd0);
        step();
        wide_valid  = 1'b0;
        quad_valid  = 1'b1;
        quad_data   = 40'h12_3456_7890;
        push(2'd1, 70'h12_3456_7891);
        step();
        quad_valid  = 1'b0;
        small_valid = 1'b1;
        small_data  = 2'd2;
        push(2'd0, 70'd3);
        step();
        small_valid = 1'b0;
        step();

        // Backpressure: wide=7 held for 5+ cycles with others waiting.
        wide_valid = 1'b1;
        wide_data  = 70'd7;
        push(2'd2, 70'd8);
        step();
        wide_valid  = 1'b0;
        rsp_ready   = 1'b0;
        small_valid = 1'b1;
        small_data  = 2'd1;
        quad_valid  = 1'b1;
        quad_data   = 40'd20;
        repeat (5) begin
            @(negedge clk);
            chk("stall_rsp_valid", WW'(rsp_valid), 1);
            chk("stall_busy", WW'(busy), 1);
            chk("stall_rsp_id", WW'(rsp_id), 2);
            chk("stall_rsp_data", rsp_data, 8);
            chk("stall_readies", WW'({small_ready, quad_ready, wide_ready}), 0);
        end
        step();
        rsp_ready = 1'b1;
        #1;
        chk("release_readies", WW'({small_ready, quad_ready, wide_ready}), 4);
        push(2'd0, 70'd2);
        push(2'd1, 70'd21);
        step();
        small_valid = 1'b0;
        step();
        quad_valid = 1'b0;
        step();

        // Reset while a response is pending.
        rsp_ready  = 1'b0;
        quad_valid = 1'b1;
        quad_data  = 40'd4;
        step();
        quad_valid  = 1'b0;
        small_valid = 1'b1;
        small_data  = 2'd2;
        wide_valid  = 1'b1;
        wide_data   = 70'd50;
        chk("pre_reset_rsp_valid", WW'(rsp_valid), 1);
        reset_l = 1'b0;
        #1;
        chk("midreset_rsp_valid", WW'(rsp_valid), 0);
        chk("midreset_busy", WW'(busy), 0);
        chk("midreset_rsp_id", WW'(rsp_id), 0);
        chk("midreset_rsp_data", rsp_data, 0);
        chk("midreset_readies", WW'({small_ready, quad_ready, wide_ready}), 0);
        #1;
        reset_l   = 1'b1;
        rsp_ready = 1'b1;
        #1;
        chk("postreset_readies", WW'({small_ready, quad_ready, wide_ready}), 4);
        push(2'd0, 70'd3);
        push(2'd2, 70'd51);
        step();
        small_valid = 1'b0;
        step();
        wide_valid = 1'b0;
        step();

        // Quad alone: a grant every cycle.
        for (int i = 0; i < 8; i++) begin
            quad_valid = 1'b1;
            quad_data  = QW'(100 + i);
            push(2'd1, WW'(101 + i));
            #1;
            chk("quad_stream_ready", WW'(quad_ready), 1);
            step();
        end
        quad_valid = 1'b0;
        step();
        step();

`ifdef INCR_SCHED_STATS_EN
        reset_l = 1'b0;
        #1;
        chk("cnt_cleared", WW'({grant_cnt_small, grant_cnt_quad, grant_cnt_wide}), 0);
        #1;
        reset_l     = 1'b1;
        small_valid = 1'b1;
        small_data  = 2'd0;
        repeat (20) push(2'd0, 70'd1);
        repeat (20) step();
        small_valid = 1'b0;
        step();
        chk("cnt_small_sat", WW'(grant_cnt_small), 15);
        chk("cnt_quad", WW'(grant_cnt_quad), 0);
        chk("cnt_wide", WW'(grant_cnt_wide), 0);
`endif

        step();
        chk("scoreboard_drained", WW'(exp_q.size()), 0);
        summary();
        $finish;
    end

endmodule
